gen_clk_multi: RTL and testbench
================================

# gen_clk_multi

Parametrised multi-channel clock divider, the successor to the three-output `gen_clk`. It derives NCH square-wave clocks from rawclk (clk1 on XEM6010), for example neuron_clk, sim_clk and spindle_clk. Each channel has its own half-period, which can be reprogrammed at runtime from okTriggerIn/okWireIn logic without glitches. It also provides global run/freeze, a sync strobe that phase-aligns all channels, a per-channel rising-edge strobe and a per-channel edge counter that replaces int_neuron_cnt_out.

## Interface
- NCH, 3: number of output channels (1..16)
- CW, 32: half-period count width
- ECW, 32: per-channel edge counter width
- DEFAULT_HALF, 32'd50000: reset half-period for every channel
- rawclk  in  1: source clock; all logic is on its rising edge
- reset_global  in  1: reset, asynchronous, active-high
- run  in  1: 1 = counting, 0 = freeze
- sync  in  1: one-cycle pulse that realigns all channels
- cfg_wr  in  1: one-cycle pulse that writes cfg_half to channel cfg_ch
- cfg_ch  in  4: target channel index
- cfg_half  in  CW: new half-period H in rawclk cycles; 0 disables the channel
- clk_out  out  NCH: divided clocks, bit i = channel i
- rise_stb  out  NCH: one-cycle strobe, high in the same cycle clk_out[i] goes 0->1
- pending  out  NCH: a reload is queued for channel i
- edge_cnt  out  NCH*ECW: rising-edge count of channel i in bits [i*ECW +: ECW]

## Operation
Per-channel state:
- phase counter cnt (CW)
- active half-period hcur
- queued half-period hnext
- pending flag
- output level
- edge counter

Reset (asynchronous):
- clk_out = 0, rise_stb = 0, pending = 0, edge_cnt = 0
- cnt = 0, hcur = hnext = DEFAULT_HALF

Counting (run = 1, hcur != 0):
- Each cycle: if cnt == hcur-1, then cnt <= 0 and clk_out toggles; otherwise cnt++.
- Result: period 2*hcur, duty 50%; the low phase comes first after reset.
- A 0->1 toggle asserts rise_stb for that one cycle and increments edge_cnt. edge_cnt wraps modulo 2^ECW with no flag.

Reload:
- cfg_wr with cfg_ch < NCH: hnext <= cfg_half, pending <= 1.
- cfg_wr with cfg_ch >= NCH is ignored.
- Repeated writes before the boundary: last value wins.
- The queued value is applied at the next period boundary, i.e. the cycle in which clk_out toggles 1->0. At that point hcur <= hnext, pending <= 0, cnt <= 0. A running clock is therefore never shortened or stretched mid-period.
- If the channel is disabled (hcur == 0), the reload is applied on the next cycle. Counting then starts in the low phase from cnt = 0.

Disable:
- hcur == 0: clk_out held 0, cnt held 0, no strobes.
- Writing 0 to a running channel takes effect at its next falling boundary.

Freeze:
- run = 0: cnt, clk_out and edge_cnt all hold; rise_stb = 0.
- Pending reloads stay queued until a boundary occurs after run returns to 1. Exception: a disabled channel still reloads immediately.

Sync (any run value):
- Every channel applies hnext if pending, clears pending and sets cnt <= 0.
- Every channel whose post-sync H != 0 goes clk_out <= 1 with rise_stb = 1 and edge_cnt++.
- Channels whose post-sync H == 0 go clk_out <= 0.
- Priority when events coincide in one cycle: reset > sync > boundary reload > cfg_wr.
  - cfg_wr coincident with sync: the new value becomes pending and is not applied by that sync.
  - cfg_wr coincident with a boundary: the boundary uses the old hnext, and the new value stays pending.

## Timing
- All outputs are registered, with no combinational path from any input.
- cfg_wr in cycle t: pending visible at t+1.
- sync in cycle t: clk_out = 1 and rise_stb at t+1 on all enabled channels, mutually edge-aligned.
- After sync with H: the first falling edge is H cycles after the rising edge, and the next rising edge is 2H cycles after it.
- run deasserted in cycle t: no state change from the t+1 edge onward.
- Reset deassertion: the first count happens on the first rawclk edge after release. The first rising edge of channel i comes H cycles later.
- Reset mid-period: outputs drop to 0 asynchronously; queued reloads are discarded.

## Test plan
- Reset, run = 1, ch0 H = 4 via cfg_wr (applied immediately, since the channel starts disabled only if DEFAULT_HALF = 0; otherwise at the first boundary) -> clk_out[0] period 8, 4 high/4 low; edge_cnt[0] = 10 after 80 cycles.
- ch1 running H = 5; cfg_wr H = 2 mid-high-phase -> the current high phase completes 5 cycles; pending = 1 until the falling edge; then period 4; no pulse shorter than 2.
- Channels H = 2, 3, 7; pulse sync -> all clk_out rise in the same cycle (t+1), rise_stb = 3'b111; subsequent rises at 4-, 6- and 14-cycle intervals.
- cfg_wr H = 0 on ch2 while running -> goes low at the next boundary and stays low; pending clears; edge_cnt[2] is frozen. cfg_ch = 9 with NCH = 3 -> no change anywhere.
- run = 0 mid-high-phase for 20 cycles -> clk_out holds 1, no rise_stb, edge_cnt constant; resumes with the remaining count on run = 1.
- ECW = 4, H = 1 -> edge_cnt wraps 15 -> 0 on the 16th rise. Assert reset_global mid-count -> clk_out = 0 and edge_cnt = 0 immediately, pending cleared.

Source files
------------

// File: rtl/gen_clk_multi_if.sv
// Control and status bundle for gen_clk_multi: run/sync/config in, divided clocks and status out.
interface gen_clk_multi_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = 32,
    parameter int unsigned ECW = 32
);
    logic                 run;
    logic                 sync;
    logic                 cfg_wr;
    logic [3:0]           cfg_ch;
    logic [CW-1:0]        cfg_half;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       rise_stb;
    logic [NCH-1:0]       pending;
    logic [NCH*ECW-1:0]   edge_cnt;

    modport master (
        output run, sync, cfg_wr, cfg_ch, cfg_half,
        input  clk_out, rise_stb, pending, edge_cnt
    );

    modport slave (
        input  run, sync, cfg_wr, cfg_ch, cfg_half,
        output clk_out, rise_stb, pending, edge_cnt
    );
endinterface

// File: rtl/gen_clk_multi.sv
// NCH-channel 50% duty clock divider with glitch-free runtime half-period reload,
// global freeze, phase-aligning sync and per-channel rising-edge counters.
module gen_clk_multi #(
    parameter int unsigned    NCH          = 3,
    parameter int unsigned    CW           = 32,
    parameter int unsigned    ECW          = 32,
    parameter logic [CW-1:0]  DEFAULT_HALF = CW'(50000)
) (
    input logic          rawclk,
    input logic          reset_global,
    gen_clk_multi_if.slave bus
);

    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [CW-1:0]  hcur_q  [NCH];
    logic [CW-1:0]  hcur_d  [NCH];
    logic [CW-1:0]  hnext_q [NCH];
    logic [CW-1:0]  hnext_d [NCH];
    logic [ECW-1:0] ecnt_q  [NCH];
    logic [ECW-1:0] ecnt_d  [NCH];
    logic [NCH-1:0] lvl_q, lvl_d;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [CW-1:0]  h_eff;
    logic           wr_hit;

    always_comb begin
        h_eff  = '0;
        wr_hit = 1'b0;
        lvl_d  = lvl_q;
        pend_d = pend_q;
        rise_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]   = cnt_q[i];
            hcur_d[i]  = hcur_q[i];
            hnext_d[i] = hnext_q[i];
            ecnt_d[i]  = ecnt_q[i];

            wr_hit = bus.cfg_wr && (int'(bus.cfg_ch) == i);
            h_eff  = pend_q[i] ? hnext_q[i] : hcur_q[i];

            if (bus.sync) begin
                // Sync consumes any queued reload and restarts every channel at a rising edge.
                hcur_d[i] = h_eff;
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                if (h_eff != '0) begin
                    lvl_d[i]  = 1'b1;
                    rise_d[i] = 1'b1;
                    ecnt_d[i] = ecnt_q[i] + ECW'(1);
                end else begin
                    lvl_d[i] = 1'b0;
                end
            end else if (hcur_q[i] == '0) begin
                cnt_d[i] = '0;
                lvl_d[i] = 1'b0;
                if (pend_q[i]) begin
                    hcur_d[i] = hnext_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (bus.run) begin
                if (cnt_q[i] == hcur_q[i] - CW'(1)) begin
                    cnt_d[i] = '0;
                    lvl_d[i] = ~lvl_q[i];
                    if (!lvl_q[i]) begin
                        rise_d[i] = 1'b1;
                        ecnt_d[i] = ecnt_q[i] + ECW'(1);
                    end else if (pend_q[i]) begin
                        // Falling edge is the period boundary: only here may the period change.
                        hcur_d[i] = hnext_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end

            if (wr_hit) begin
                hnext_d[i] = bus.cfg_half;
                pend_d[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge rawclk or posedge reset_global) begin
        if (reset_global) begin
            lvl_q  <= '0;
            rise_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= '0;
                hcur_q[i]  <= DEFAULT_HALF;
                hnext_q[i] <= DEFAULT_HALF;
                ecnt_q[i]  <= '0;
            end
        end else begin
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            pend_q <= pend_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                hcur_q[i]  <= hcur_d[i];
                hnext_q[i] <= hnext_d[i];
                ecnt_q[i]  <= ecnt_d[i];
            end
        end
    end

    logic [NCH*ECW-1:0] ecnt_flat;

    always_comb begin
        ecnt_flat = '0;
        for (int i = 0; i < NCH; i++) begin
            ecnt_flat[i*ECW +: ECW] = ecnt_q[i];
        end
    end

    assign bus.clk_out  = lvl_q;
    assign bus.rise_stb = rise_q;
    assign bus.pending  = pend_q;
    assign bus.edge_cnt = ecnt_flat;

endmodule

// File: tb/tb_gen_clk_multi.sv
// Bench for gen_clk_multi: period-position reference model checked every cycle,
// plus directed literal checks on sync alignment, reload, disable, freeze and wrap.
module tb_gen_clk_multi;
    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned ECW = 4;
    localparam logic [7:0]  DH  = 8'd3;

    logic rawclk = 1'b0;
    logic reset_global = 1'b0;

    gen_clk_multi_if #(.NCH(NCH), .CW(CW), .ECW(ECW)) bus ();

    gen_clk_multi #(
        .NCH(NCH), .CW(CW), .ECW(ECW), .DEFAULT_HALF(DH)
    ) dut (
        .rawclk(rawclk),
        .reset_global(reset_global),
        .bus(bus)
    );

    always #5 rawclk = ~rawclk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel sits at a position pos within a period of 2H; high when pos >= H.
    int m_h[NCH], m_hq[NCH], m_pos[NCH], m_ecnt[NCH];
    bit m_pend[NCH], m_rise[NCH];

    always @(posedge rawclk or posedge reset_global) begin
        if (reset_global) begin
            for (int i = 0; i < NCH; i++) begin
                m_h[i] = int'(DH); m_hq[i] = int'(DH); m_pos[i] = 0;
                m_ecnt[i] = 0; m_pend[i] = 0; m_rise[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_rise[i] = 0;
                if (bus.sync) begin
                    if (m_pend[i]) m_h[i] = m_hq[i];
                    m_pend[i] = 0;
                    if (m_h[i] != 0) begin
                        m_pos[i] = m_h[i];
                        m_rise[i] = 1;
                        m_ecnt[i] = (m_ecnt[i] + 1) % (1 << ECW);
                    end else begin
                        m_pos[i] = 0;
                    end
                end else if (m_h[i] == 0) begin
                    m_pos[i] = 0;
                    if (m_pend[i]) begin
                        m_h[i] = m_hq[i];
                        m_pend[i] = 0;
                    end
                end else if (bus.run) begin
                    m_pos[i]++;
                    if (m_pos[i] == m_h[i]) begin
                        m_rise[i] = 1;
                        m_ecnt[i] = (m_ecnt[i] + 1) % (1 << ECW);
                    end
                    if (m_pos[i] == 2 * m_h[i]) begin
                        m_pos[i] = 0;
                        if (m_pend[i]) begin
                            m_h[i] = m_hq[i];
                            m_pend[i] = 0;
                        end
                    end
                end
                if (bus.cfg_wr && int'(bus.cfg_ch) == i) begin
                    m_hq[i] = int'(bus.cfg_half);
                    m_pend[i] = 1;
                end
            end
        end
    end

    function automatic int unsigned m_clk();
        int unsigned v = 0;
        for (int i = 0; i < NCH; i++)
            if (m_h[i] != 0 && m_pos[i] >= m_h[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int unsigned m_rises();
        int unsigned v = 0;
        for (int i = 0; i < NCH; i++) if (m_rise[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int unsigned m_pends();
        int unsigned v = 0;
        for (int i = 0; i < NCH; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int unsigned m_edges();
        int unsigned v = 0;
        for (int i = 0; i < NCH; i++) v |= (m_ecnt[i] << (i * ECW));
        return v;
    endfunction

    always @(negedge rawclk) begin
        if (!reset_global) begin
            check("model_clk_out", bus.clk_out, m_clk());
            check("model_rise_stb", bus.rise_stb, m_rises());
            check("model_pending", bus.pending, m_pends());
            check("model_edge_cnt", bus.edge_cnt, m_edges());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge rawclk);
        #1;
    endtask

    task automatic write(input int ch, input int h);
        bus.cfg_ch = 4'(ch);
        bus.cfg_half = 8'(h);
        bus.cfg_wr = 1'b1;
        step(1);
        bus.cfg_wr = 1'b0;
    endtask

    task automatic pulse_sync();
        bus.sync = 1'b1;
        step(1);
        bus.sync = 1'b0;
    endtask

    initial begin
        int unsigned exp_r;
        bus.run = 1'b0; bus.sync = 1'b0; bus.cfg_wr = 1'b0;
        bus.cfg_ch = '0; bus.cfg_half = '0;
        #2 reset_global = 1'b1;
        step(1);
        check("reset_clk_out", bus.clk_out, 0);
        check("reset_rise_stb", bus.rise_stb, 0);
        check("reset_pending", bus.pending, 0);
        check("reset_edge_cnt", bus.edge_cnt, 0);
        reset_global = 1'b0;

        // ch0 H=4 aligned by sync, then 80 cycles of counting
        write(0, 4);
        check("wr_pending", bus.pending, 3'b001);
        bus.run = 1'b1;
        pulse_sync();
        check("sync_clk_all", bus.clk_out, 3'b111);
        check("sync_rise_all", bus.rise_stb, 3'b111);
        check("sync_edge0", bus.edge_cnt[0 +: ECW], 1);
        step(80);
        check("edge0_after80", bus.edge_cnt[0 +: ECW], 11);
        check("rise0_after80", bus.rise_stb[0], 1);

        // ch1 H=5, reload to H=2 in the middle of the high phase
        write(1, 5);
        pulse_sync();
        step(1);
        write(1, 2);
        check("mid_pending1", bus.pending, 3'b010);
        step(2);
        check("hold_high1", bus.clk_out[1], 1);
        check("still_pend1", bus.pending[1], 1);
        step(1);
        check("fall_at5", bus.clk_out[1], 0);
        check("pend_clear1", bus.pending[1], 0);
        step(2);
        check("new_rise1", bus.clk_out[1], 1);
        check("new_stb1", bus.rise_stb[1], 1);
        step(2);
        check("new_fall1", bus.clk_out[1], 0);

        // H = 2,3,7 aligned by sync
        write(0, 2);
        write(1, 3);
        write(2, 7);
        pulse_sync();
        check("align_clk", bus.clk_out, 3'b111);
        check("align_rise", bus.rise_stb, 3'b111);
        for (int k = 1; k <= 28; k++) begin
            step(1);
            exp_r = 0;
            if (k % 4 == 0) exp_r |= 1;
            if (k % 6 == 0) exp_r |= 2;
            if (k % 14 == 0) exp_r |= 4;
            check("interval_rise", bus.rise_stb, exp_r);
        end

        // disable ch2 while running; out-of-range channel write
        write(2, 0);
        step(20);
        check("dis_clk2", bus.clk_out[2], 0);
        check("dis_pend2", bus.pending[2], 0);
        write(9, 1);
        check("bad_ch_pending", bus.pending, 0);

        // freeze in the middle of the high phase
        write(0, 4);
        pulse_sync();
        step(2);
        bus.run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("frz_clk0", bus.clk_out[0], 1);
            check("frz_rise", bus.rise_stb, 0);
        end
        bus.run = 1'b1;
        step(1);
        check("resume_hi", bus.clk_out[0], 1);
        step(1);
        check("resume_fall", bus.clk_out[0], 0);

        // edge counter wrap with H=1
        reset_global = 1'b1;
        step(1);
        reset_global = 1'b0;
        write(0, 1);
        pulse_sync();
        step(28);
        check("wrap_15", bus.edge_cnt[0 +: ECW], 15);
        step(2);
        check("wrap_0", bus.edge_cnt[0 +: ECW], 0);
        check("wrap_rise", bus.rise_stb[0], 1);

        // asynchronous reset mid-count discards queued reload
        write(1, 9);
        check("pre_rst_pend", bus.pending[1], 1);
        #1 reset_global = 1'b1;
        #1;
        check("arst_clk", bus.clk_out, 0);
        check("arst_edge", bus.edge_cnt, 0);
        check("arst_pend", bus.pending, 0);
        check("arst_rise", bus.rise_stb, 0);
        step(1);
        reset_global = 1'b0;
        step(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
